// File: rtl/step_pulse_gen.sv
// Step / auto-run pulse generator producing spaced one-cycle PCclk pulses.
// Define STEP_AUTORUN_EN to build the run-mode timer (run_en, halt).
module step_pulse_gen #(
  parameter int DEBOUNCE_CNT = 16,
  parameter int MIN_GAP      = 64,
  parameter int RUN_PERIOD   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        run_en,
  input  logic        halt,
  output logic        PCclk,
  output logic        busy,
  output logic [15:0] step_count
);

  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam int GW = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(MIN_GAP - 2);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t          state, state_n;
  logic            b_s1, btn_s;
  logic            db_level, db_prev;
  logic [DW-1:0]   db_cnt;
  logic            press, tick, pending, req, take;
  logic [GW-1:0]   gap_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_s1     <= 1'b0;
      btn_s    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      b_s1    <= btn_step;
      btn_s   <= b_s1;
      db_prev <= db_level;
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = db_level & ~db_prev;

`ifdef STEP_AUTORUN_EN
  localparam int PW = $clog2(RUN_PERIOD);
  localparam logic [PW-1:0] PER_LAST = PW'(RUN_PERIOD - 1);

  logic          r_s1, run_s, run_act;
  logic [PW-1:0] per_cnt;

  assign run_act = run_s & ~halt;
  assign tick    = run_act && (per_cnt == PER_LAST);

  // Restart the period on every pulse so auto-run stays phase-locked to it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      run_s   <= 1'b0;
      per_cnt <= '0;
    end else begin
      r_s1  <= run_en;
      run_s <= r_s1;
      if (!run_act || tick || state_n == PULSE)
        per_cnt <= '0;
      else
        per_cnt <= per_cnt + 1'b1;
    end
  end
`else
  logic unused_run;
  assign unused_run = run_en ^ halt;
  assign tick       = 1'b0;
`endif

  assign req = press | tick | pending;

  always_comb begin
    state_n = state;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_n = PULSE;
          take    = 1'b1;
        end
      end
      PULSE: state_n = GAP;
      GAP: begin
        if (gap_cnt == '0) begin
          if (req) begin
            state_n = PULSE;
            take    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      pending    <= 1'b0;
      PCclk      <= 1'b0;
      busy       <= 1'b0;
      step_count <= '0;
    end else begin
      state <= state_n;
      PCclk <= (state_n == PULSE);
      busy  <= (state_n != IDLE);
      if (state == PULSE) begin
        gap_cnt    <= GAP_INIT;
        step_count <= step_count + 16'd1;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      // One-deep: extra requests while pending merge into it
      if (take)
        pending <= 1'b0;
      else if (press | tick)
        pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: expected pulses are queued by
// stimulus and matched by a negedge monitor.
module tb_step_pulse_gen;
  localparam int DB  = 4;
  localparam int GP  = 64;
  localparam int PER = 100;

  logic        clk = 1'b0;
  logic        rst, btn_step, run_en, halt;
  logic        PCclk, busy;
  logic [15:0] step_count;

  always #5 clk = ~clk;

  step_pulse_gen #(
    .DEBOUNCE_CNT(DB),
    .MIN_GAP(GP),
    .RUN_PERIOD(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_step(btn_step),
    .run_en(run_en),
    .halt(halt),
    .PCclk(PCclk),
    .busy(busy),
    .step_count(step_count)
  );

  typedef struct {
    int          at;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          busy_cyc = 0;
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_cyc++;
    if (PCclk === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse at %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_count", {16'd0, step_count}, {16'd0, e.cnt});
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int at);
    q.push_back('{at, exp_cnt});
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic hold_btn(input int n);
    btn_step = 1'b1;
    wait_n(n);
    btn_step = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_n(2);
    rst = 1'b0;
    exp_cnt = 16'd0;
    wait_n(3);
  endtask

  int e0;

  initial begin
    rst = 1'b1;
    btn_step = 1'b0;
    run_en = 1'b0;
    halt = 1'b0;
    wait_n(3);
    chk("reset_pcclk", {31'd0, PCclk}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_count", {16'd0, step_count}, 32'd0);
    rst = 1'b0;
    wait_n(5);

    // clean press, held long, release makes nothing
    busy_cyc = 0;
    e0 = cyc + 1;
    expect_pulse(e0 + DB + 2);
    hold_btn(200);
    wait_n(100);
    chk("clean_count", {16'd0, step_count}, 32'd1);
    chk("clean_busy_cycles", busy_cyc, GP);
    chk("clean_queue", q.size(), 0);

    // bounce: 2-cycle toggles, then settle high
    do_reset();
    for (int k = 0; k < 16; k++) begin
      btn_step = (k % 2 == 0);
      wait_n(2);
    end
    e0 = cyc + 1;
    expect_pulse(e0 + DB + 2);
    btn_step = 1'b1;
    wait_n(50);
    btn_step = 1'b0;
    wait_n(100);
    chk("bounce_count", {16'd0, step_count}, 32'd1);

    // two presses 20 apart, third dropped while pending
    do_reset();
    e0 = cyc + 1;
    expect_pulse(e0 + DB + 2);
    expect_pulse(e0 + DB + 2 + GP);
    hold_btn(10);
    wait_n(10);
    hold_btn(10);
    wait_n(10);
    hold_btn(10);
    wait_n(150);
    chk("spacing_count", {16'd0, step_count}, 32'd2);

    // reset in GAP with a pending request
    do_reset();
    e0 = cyc + 1;
    expect_pulse(e0 + DB + 2);
    hold_btn(10);
    wait_n(10);
    hold_btn(10);
    wait_n(7);
    rst = 1'b1;
    wait_n(1);
    chk("midgap_pcclk", {31'd0, PCclk}, 32'd0);
    chk("midgap_busy", {31'd0, busy}, 32'd0);
    chk("midgap_count", {16'd0, step_count}, 32'd0);
    rst = 1'b0;
    exp_cnt = 16'd0;
    wait_n(150);
    chk("midgap_after", {16'd0, step_count}, 32'd0);

    // button held through reset gives exactly one pulse
    rst = 1'b1;
    btn_step = 1'b1;
    wait_n(5);
    exp_cnt = 16'd0;
    e0 = cyc + 1;
    expect_pulse(e0 + DB + 2);
    rst = 1'b0;
    wait_n(100);
    btn_step = 1'b0;
    wait_n(30);
    chk("held_reset_count", {16'd0, step_count}, 32'd1);

    // step_count wraps
    force dut.step_count = 16'hFFFF;
    wait_n(1);
    release dut.step_count;
    exp_cnt = 16'hFFFF;
    e0 = cyc + 1;
    expect_pulse(e0 + DB + 2);
    hold_btn(10);
    wait_n(80);
    chk("wrap_count", {16'd0, step_count}, 32'd0);

`ifdef STEP_AUTORUN_EN
    // auto-run, halt, manual press while halted
    do_reset();
    busy_cyc = 0;
    e0 = cyc + 1;
    expect_pulse(e0 + PER + 1);
    expect_pulse(e0 + 2 * PER + 1);
    expect_pulse(e0 + 3 * PER + 1);
    run_en = 1'b1;
    wait_n(e0 + 3 * PER + 20 - cyc);
    halt = 1'b1;
    wait_n(200);
    chk("halt_count", {16'd0, step_count}, 32'd3);
    e0 = cyc + 1;
    expect_pulse(e0 + DB + 2);
    hold_btn(10);
    wait_n(100);
    run_en = 1'b0;
    wait_n(5);
    halt = 1'b0;
    wait_n(150);
    chk("run_count", {16'd0, step_count}, 32'd4);
    chk("run_busy_cycles", busy_cyc, 4 * GP);
`endif

    chk("final_queue", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
